uart_tx_port: RTL and testbench

UART_TX_PORT -- requirements
Module: uart_tx_port

---
 rtl/uart_tx_port_if.sv | 25 ++
 rtl/uart_tx_port.sv | 150 +++++++++++++++
 tb/tb_uart_tx_port.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_port_if.sv
// CPU output-port side of the UART transmitter: write strobe, data, overflow clear,
// and the status byte plus serial line returned to the CPU/board.
interface uart_tx_port_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_ovf;
  logic [7:0] status;
  logic       tx;

  modport master (
    output wr_en,
    output wr_data,
    output clr_ovf,
    input  status,
    input  tx
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    input  clr_ovf,
    output status,
    output tx
  );
endinterface

// File: rtl/uart_tx_port.sv
// 8N1 UART transmitter behind a 4-entry byte FIFO, with a CPU-readable status byte
// {ovf, 0, busy, full, empty, count[2:0]} built entirely from registers.
module uart_tx_port #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_port_if.slave  bus
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_reg;
  logic [7:0]        mem [4];
  logic [1:0]        wr_ptr_reg;
  logic [1:0]        rd_ptr_reg;
  logic [2:0]        count_reg;
  logic [2:0]        count_next;
  logic              ovf_reg;
  logic              empty_reg;
  logic              full_reg;
  logic              busy_reg;
  logic              tx_reg;
  logic [7:0]        shift_reg;
  logic [2:0]        bit_reg;
  logic [BAUD_W-1:0] baud_reg;
  logic              pop;
  logic              push;
  logic              drop;

  // A pop frees a slot on the same edge, so a write to a full FIFO is only
  // dropped when the transmitter is not taking the head this cycle.
  always_comb begin
    pop        = (state_reg == IDLE) && (count_reg != 3'd0);
    push       = bus.wr_en && ((count_reg != 3'd4) || pop);
    drop       = bus.wr_en && !push;
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 3'd1;
      2'b01:   count_next = count_reg - 3'd1;
      default: count_next = count_reg;
    endcase
  end

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= 2'd0;
      rd_ptr_reg <= 2'd0;
      count_reg  <= 3'd0;
      empty_reg  <= 1'b1;
      full_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 2'd1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 2'd1;
      end
      count_reg <= count_next;
      empty_reg <= (count_next == 3'd0);
      full_reg  <= (count_next == 3'd4);
      // Set has priority over clear so a simultaneous overflow is never lost.
      if (drop) begin
        ovf_reg <= 1'b1;
      end else if (bus.clr_ovf) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      shift_reg <= 8'd0;
      bit_reg   <= 3'd0;
      baud_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          tx_reg   <= 1'b1;
          busy_reg <= 1'b0;
          if (pop) begin
            shift_reg <= mem[rd_ptr_reg];
            bit_reg   <= 3'd0;
            baud_reg  <= '0;
            tx_reg    <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= START;
          end
        end
        START: begin
          if (baud_reg == BAUD_LAST) begin
            baud_reg  <= '0;
            tx_reg    <= shift_reg[0];
            state_reg <= DATA;
          end else begin
            baud_reg <= baud_reg + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_reg == BAUD_LAST) begin
            baud_reg <= '0;
            if (bit_reg == 3'd7) begin
              tx_reg    <= 1'b1;
              state_reg <= STOP;
            end else begin
              // Drive the next bit straight from the pre-shift value.
              bit_reg   <= bit_reg + 3'd1;
              shift_reg <= shift_reg >> 1;
              tx_reg    <= shift_reg[1];
            end
          end else begin
            baud_reg <= baud_reg + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_reg == BAUD_LAST) begin
            baud_reg  <= '0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            baud_reg <= baud_reg + BAUD_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.status = {ovf_reg, 1'b0, busy_reg, full_reg, empty_reg, count_reg};
  assign bus.tx     = tx_reg;

endmodule

// File: tb/tb_uart_tx_port.sv
// Randomized and directed bench for uart_tx_port; a frame-position model predicts the
// line level and status byte after every clock edge.
module tb_uart_tx_port;

  localparam int CPB = 4;

  logic clk;
  logic reset;

  uart_tx_port_if bus ();

  uart_tx_port #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_count = 0;
  int err_count = 0;

  // Model: queued bytes, sticky overflow, and position inside the current frame
  // (-1 when the line is idle); line bit index = position / CPB.
  logic [7:0] mq[$];
  logic [7:0] m_cur;
  logic       m_ovf;
  int         m_pos;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_cur = 8'h00;
    m_ovf = 1'b0;
    m_pos = -1;
  endfunction

  function automatic logic model_tx();
    int b;
    if (m_pos < 0) return 1'b1;
    b = m_pos / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  function automatic logic [7:0] model_status();
    int n;
    n = mq.size();
    return {m_ovf, 1'b0, (m_pos >= 0), (n == 4), (n == 0), 3'(n)};
  endfunction

  function automatic bit model_pop_next();
    return (m_pos < 0) && (mq.size() > 0);
  endfunction

  // Returns 1 if the write was accepted.
  function automatic bit model_edge(input logic we, input logic [7:0] d, input logic clr);
    bit pop;
    bit set;
    bit acc;
    int sz;
    sz  = mq.size();
    pop = model_pop_next();
    set = 1'b0;
    acc = 1'b0;
    if (pop) begin
      m_cur = mq.pop_front();
      m_pos = 0;
    end else if (m_pos >= 0) begin
      m_pos++;
      if (m_pos == 10 * CPB) m_pos = -1;
    end
    if (we) begin
      if (sz < 4 || pop) begin
        mq.push_back(d);
        acc = 1'b1;
      end else begin
        set = 1'b1;
      end
    end
    if (set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    return acc;
  endfunction

  task automatic tick(input logic we, input logic [7:0] d, input logic clr);
    bit acc;
    bus.wr_en   = we;
    bus.wr_data = d;
    bus.clr_ovf = clr;
    @(posedge clk);
    acc = model_edge(we, d, clr);
    #1;
    if (we) $display("t=%0t write %02h %s", $time, d, acc ? "accepted" : "dropped");
    check_eq("tx", {7'b0, bus.tx}, {7'b0, model_tx()});
    check_eq("status", bus.status, model_status());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_pop_next(input int limit);
    int n;
    n = 0;
    while (!model_pop_next() && n < limit) begin
      tick(1'b0, 8'h00, 1'b0);
      n++;
    end
    check_eq("wait_pop", {7'b0, (n < limit)}, 8'h01);
  endtask

  task automatic async_reset();
    bus.wr_en   = 1'b0;
    bus.clr_ovf = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("arst_tx", {7'b0, bus.tx}, 8'h01);
    check_eq("arst_status", bus.status, 8'h08);
    @(posedge clk);
    #1;
    check_eq("arst_hold_tx", {7'b0, bus.tx}, 8'h01);
    check_eq("arst_hold_status", bus.status, 8'h08);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] a5_line;
    int         busy_cnt;
    int         n;
    a5_line     = 10'b1101001010;
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_ovf = 1'b0;
    model_reset();

    #3;
    check_eq("reset_status", bus.status, 8'h08);
    check_eq("reset_tx", {7'b0, bus.tx}, 8'h01);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single 0xA5 frame: fixed line pattern, 40 busy cycles.
    tick(1'b1, 8'hA5, 1'b0);
    busy_cnt = 0;
    for (int k = 0; k < 45; k++) begin
      tick(1'b0, 8'h00, 1'b0);
      if (bus.status[5]) busy_cnt++;
      if (k < 40 && (k % CPB) == 1)
        check_eq($sformatf("a5_bit%0d", k / CPB), {7'b0, bus.tx}, {7'b0, a5_line[k / CPB]});
    end
    check_eq("a5_busy_len", 8'(busy_cnt), 8'd40);
    check_eq("a5_end_status", bus.status, 8'h08);

    // Six back-to-back writes: one popped, four buffered, one dropped.
    for (int i = 1; i <= 6; i++) tick(1'b1, 8'(i), 1'b0);
    check_eq("burst_status", bus.status, 8'hB4);
    idle(5 * 41 + 5);
    check_eq("burst_end_status", bus.status, 8'h88);

    tick(1'b0, 8'h00, 1'b1);
    check_eq("ovf_clear", {7'b0, bus.status[7]}, 8'h00);

    // Write into a full FIFO on the very edge the head is popped.
    for (int i = 0; i < 5; i++) tick(1'b1, 8'h10 + 8'(i), 1'b0);
    wait_pop_next(100);
    tick(1'b1, 8'hC3, 1'b0);
    check_eq("pop_write_ovf", {7'b0, bus.status[7]}, 8'h00);
    check_eq("pop_write_count", {5'b0, bus.status[2:0]}, 8'h04);
    idle(5 * 41 + 5);

    // Overflowing write together with clr_ovf: set wins.
    for (int i = 0; i < 5; i++) tick(1'b1, 8'h20 + 8'(i), 1'b0);
    tick(1'b1, 8'hEE, 1'b1);
    check_eq("set_wins", {7'b0, bus.status[7]}, 8'h01);
    tick(1'b0, 8'h00, 1'b1);
    idle(5 * 41 + 5);

    // Reset in data bit 3 with two bytes still queued.
    for (int i = 0; i < 3; i++) tick(1'b1, 8'h5A + 8'(i), 1'b0);
    n = 0;
    while (m_pos != 4 * CPB + 1 && n < 100) begin
      tick(1'b0, 8'h00, 1'b0);
      n++;
    end
    check_eq("wait_bit3", {7'b0, (n < 100)}, 8'h01);
    async_reset();
    idle(50);

    // Four writes then quiet: drains one per frame.
    for (int i = 0; i < 4; i++) tick(1'b1, 8'h80 + 8'(i), 1'b0);
    idle(4 * 41 + 10);
    check_eq("drain_status", bus.status, 8'h08);

    // Random traffic: heavy phase forces overflow, light phase mostly drains.
    for (int i = 0; i < 1500; i++) begin
      logic we;
      logic clr;
      we  = (i < 700) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 14) == 0);
      clr = ($urandom_range(0, 39) == 0);
      tick(we, 8'($urandom), clr);
    end
    idle(5 * 41 + 5);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
